// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
//   ar_state_e     : AR channel state (idle bubble / address on the bus)
//   AXI_BURST_INCR : arburst encoding for INCR bursts
//   ARLEN_SINGLE   : arlen for a single-beat transfer
//   DEFAULT_ID_*   : default arid values for the two requesters
//   hits_write()   : word-address compare against a pending write
package axi_rd_arb_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [7:0] ARLEN_SINGLE    = 8'd0;
    localparam logic [3:0] DEFAULT_ID_INST = 4'd0;
    localparam logic [3:0] DEFAULT_ID_DATA = 4'd1;

    // A read collides with a pending write when both touch the same 32-bit word.
    function automatic logic hits_write(input logic        busy,
                                        input logic [31:0] waddr,
                                        input logic [31:0] raddr);
        return busy && (waddr[31:2] == raddr[31:2]);
    endfunction

endpackage

// File: rtl/rd_outst_counter.sv
// Saturating up/down counter tracking in-flight reads for one requester.
//   clk, reset : clock, synchronous active-high reset
//   inc        : a read was accepted this cycle
//   dec        : a read response was delivered this cycle
//   cnt        : current outstanding count
//   full       : count has reached MAX_OUTST
module rd_outst_counter #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt,
    output logic       full
);

    localparam logic [1:0] LIMIT = 2'(MAX_OUTST);

    assign full = (cnt >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt < LIMIT)
                cnt <= cnt + 2'd1;
        end else if (dec && !inc) begin
            // A stray response at zero is still forwarded upstream; only the count holds.
            if (cnt != 2'd0)
                cnt <= cnt - 2'd1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read-address/read-data channel pair between the instruction
// and data sram-like read requesters. Data has fixed priority, each port is
// limited to MAX_OUTST in-flight reads, reads hitting the word of a pending
// write are held off, and responses are routed back by rid.
//   clk, reset                       : clock, synchronous active-high reset
//   inst_req/size/addr, inst_addr_ok : instruction request side
//   inst_data_ok, inst_rdata         : instruction response side
//   data_req/size/addr, data_addr_ok : data request side
//   data_data_ok, data_rdata         : data response side
//   wr_busy, wr_addr                 : pending write from the write path
//   ar*                              : AXI read-address channel (master)
//   rid, rdata, rvalid, rready       : AXI read-data channel (master)
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  ID_INST   = DEFAULT_ID_INST,
    parameter logic [3:0]  ID_DATA   = DEFAULT_ID_DATA
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        wr_busy,
    input  logic [31:0] wr_addr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    ar_state_e   state;
    logic        inst_full;
    logic        data_full;
    logic [1:0]  inst_cnt;
    logic [1:0]  data_cnt;
    logic        inst_elig;
    logic        data_elig;
    logic        grant_inst;
    logic        grant_data;

    assign inst_elig = inst_req && !inst_full && !hits_write(wr_busy, wr_addr, inst_addr);
    assign data_elig = data_req && !data_full && !hits_write(wr_busy, wr_addr, data_addr);

    // Grants only exist in the idle bubble; reset suppresses them so nothing is
    // counted in a cycle that is about to be wiped.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (!reset && state == AR_IDLE) begin
            if (data_elig)
                grant_data = 1'b1;
            else if (inst_elig)
                grant_inst = 1'b1;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= AR_IDLE;
            arid   <= '0;
            araddr <= '0;
            arsize <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (grant_data) begin
                        arid   <= ID_DATA;
                        araddr <= data_addr;
                        arsize <= {1'b0, data_size};
                        state  <= AR_SEND;
                    end else if (grant_inst) begin
                        arid   <= ID_INST;
                        araddr <= inst_addr;
                        arsize <= {1'b0, inst_size};
                        state  <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready)
                        state <= AR_IDLE;
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    assign arvalid = (state == AR_SEND);
    assign arlen   = ARLEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign rready       = 1'b1;
    assign inst_data_ok = rvalid && (rid == ID_INST);
    assign data_data_ok = rvalid && (rid == ID_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    rd_outst_counter #(.MAX_OUTST(MAX_OUTST)) u_inst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_inst),
        .dec   (inst_data_ok),
        .cnt   (inst_cnt),
        .full  (inst_full)
    );

    rd_outst_counter #(.MAX_OUTST(MAX_OUTST)) u_data_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_data),
        .dec   (data_data_ok),
        .cnt   (data_cnt),
        .full  (data_full)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, wr_busy, arready, rvalid;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, wr_addr, rdata;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid, arcache;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, rready;

    int checks = 0;
    int failures = 0;

    // Behavioural reference: a pending-address slot plus per-port in-flight totals.
    bit          m_busy;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize;
    int          m_cnt_i, m_cnt_d;
    bit          e_iaok, e_daok, e_idok, e_ddok;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.MAX_OUTST(MAXO), .ID_INST(4'd0), .ID_DATA(4'd1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    function automatic bit blocked(logic [31:0] a);
        return wr_busy && ((wr_addr >> 2) == (a >> 2));
    endfunction

    task automatic model_eval();
        e_idok = rvalid && rid == 4'd0;
        e_ddok = rvalid && rid == 4'd1;
        e_daok = 0;
        e_iaok = 0;
        if (!reset && !m_busy) begin
            if (data_req && m_cnt_d < MAXO && !blocked(data_addr)) e_daok = 1;
            else if (inst_req && m_cnt_i < MAXO && !blocked(inst_addr)) e_iaok = 1;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_busy = 0; m_arid = '0; m_araddr = '0; m_arsize = '0;
            m_cnt_i = 0; m_cnt_d = 0;
            return;
        end
        if (e_daok) begin
            m_busy = 1; m_arid = 4'd1; m_araddr = data_addr; m_arsize = {1'b0, data_size};
        end else if (e_iaok) begin
            m_busy = 1; m_arid = 4'd0; m_araddr = inst_addr; m_arsize = {1'b0, inst_size};
        end else if (m_busy && arready) begin
            m_busy = 0;
        end
        m_cnt_d = m_cnt_d + int'(e_daok) - int'(e_ddok);
        m_cnt_i = m_cnt_i + int'(e_iaok) - int'(e_idok);
        if (m_cnt_d < 0) m_cnt_d = 0;
        if (m_cnt_i < 0) m_cnt_i = 0;
        if (m_cnt_d > MAXO) m_cnt_d = MAXO;
        if (m_cnt_i > MAXO) m_cnt_i = MAXO;
    endtask

    // Inputs are driven at the falling edge; settle lets combinational outputs
    // resolve and computes the reference expectation for this cycle.
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; wr_busy = 0; arready = 0; rvalid = 0;
        inst_size = 2'd2; data_size = 2'd2; inst_addr = '0; data_addr = '0;
        wr_addr = '0; rdata = '0; rid = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        settle();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks += 7;
        if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0h exp=0", arvalid); end
        if (arid !== 4'd0) begin failures++; $display("FAIL reset_arid got=%0h exp=0", arid); end
        if (araddr !== 32'd0) begin failures++; $display("FAIL reset_araddr got=%0h exp=0", araddr); end
        if (arsize !== 3'd0) begin failures++; $display("FAIL reset_arsize got=%0h exp=0", arsize); end
        if (rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%0h exp=1", rready); end
        if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_inst_addr_ok got=%0h exp=0", inst_addr_ok); end
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_data_addr_ok got=%0h exp=0", data_addr_ok); end
    endtask

    task automatic test_single_read();
        do_reset();
        data_req = 1; data_addr = 32'h1000; data_size = 2'd2;
        settle();
        checks += 2;
        if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok got=%0h exp=1", data_addr_ok); end
        if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL single_inst_addr_ok got=%0h exp=0", inst_addr_ok); end
        step();
        data_req = 0; data_addr = 32'hFFFF_FFFF; data_size = 2'd0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks += 8;
            if (arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid c%0d got=%0h exp=1", i, arvalid); end
            if (arid !== 4'd1) begin failures++; $display("FAIL single_arid c%0d got=%0h exp=1", i, arid); end
            if (araddr !== 32'h1000) begin failures++; $display("FAIL single_araddr c%0d got=%0h exp=1000", i, araddr); end
            if (arsize !== 3'd2) begin failures++; $display("FAIL single_arsize c%0d got=%0h exp=2", i, arsize); end
            if (arlen !== 8'd0 || arburst !== 2'b01) begin failures++; $display("FAIL single_len_burst got=%0h/%0h exp=0/1", arlen, arburst); end
            if (arlock !== 2'd0 || arcache !== 4'd0 || arprot !== 3'd0) begin failures++; $display("FAIL single_const got=%0h/%0h/%0h exp=0/0/0", arlock, arcache, arprot); end
            if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL single_no_aok_send got=%0h exp=0", data_addr_ok); end
            if (arvalid !== m_busy) begin failures++; $display("FAIL single_model_busy got=%0h exp=%0h", arvalid, m_busy); end
            step();
        end
        arready = 1;
        settle();
        step();
        arready = 0;
        rvalid = 1; rid = 4'd1; rdata = 32'hDEADBEEF;
        settle();
        checks += 4;
        if (arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_done got=%0h exp=0", arvalid); end
        if (data_data_ok !== 1'b1) begin failures++; $display("FAIL single_data_ok got=%0h exp=1", data_data_ok); end
        if (data_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%0h exp=deadbeef", data_rdata); end
        if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL single_inst_data_ok got=%0h exp=0", inst_data_ok); end
        step();
        rvalid = 0;
    endtask

    task automatic test_priority();
        do_reset();
        inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200;
        settle();
        checks += 2;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_first got=%0h%0h exp=10", data_addr_ok, inst_addr_ok); end
        step();
        data_req = 0; arready = 1;
        settle();
        if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_send_no_grant got=%0h exp=0", inst_addr_ok); end
        step();
        arready = 0;
        settle();
        checks += 2;
        if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL prio_inst_next got=%0h exp=1", inst_addr_ok); end
        step();
        inst_req = 0;
        settle();
        if (arid !== 4'd0 || araddr !== 32'h100) begin failures++; $display("FAIL prio_inst_ar got=%0h/%0h exp=0/100", arid, araddr); end
        step();
    endtask

    task automatic test_limit();
        int seen;
        do_reset();
        inst_req = 1; inst_addr = 32'h40; arready = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            inst_addr = inst_addr + 32'd4;
            settle();
            seen += int'(inst_addr_ok);
            step();
        end
        checks += 3;
        if (seen != MAXO) begin failures++; $display("FAIL limit_count got=%0d exp=%0d", seen, MAXO); end
        rvalid = 1; rid = 4'd0; rdata = 32'h1234;
        settle();
        if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b1) begin failures++; $display("FAIL limit_resp got=%0h%0h exp=01", inst_addr_ok, inst_data_ok); end
        step();
        rvalid = 0;
        settle();
        if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL limit_third got=%0h exp=1", inst_addr_ok); end
        step();
        inst_req = 0;
        step();
    endtask

    task automatic test_write_hazard();
        do_reset();
        wr_busy = 1; wr_addr = 32'h2004; data_req = 1; data_addr = 32'h2006;
        settle();
        checks += 6;
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL haz_block got=%0h exp=0", data_addr_ok); end
        step();
        settle();
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL haz_block2 got=%0h exp=0", data_addr_ok); end
        data_addr = 32'h2008;
        settle();
        if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL haz_other_word got=%0h exp=1", data_addr_ok); end
        step();
        data_req = 0; arready = 1;
        settle();
        step();
        arready = 0; inst_req = 1; inst_addr = 32'h2007;
        settle();
        if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL haz_inst_block got=%0h exp=0", inst_addr_ok); end
        inst_req = 0; data_req = 1; data_addr = 32'h2006;
        settle();
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL haz_block3 got=%0h exp=0", data_addr_ok); end
        wr_busy = 0;
        settle();
        if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL haz_release got=%0h exp=1", data_addr_ok); end
        step();
        data_req = 0;
        step();
    endtask

    task automatic test_routing();
        do_reset();
        rvalid = 1; rid = 4'd0; rdata = 32'hA5A5_0001;
        settle();
        checks += 8;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL route_rid0 got=%0h%0h exp=10", inst_data_ok, data_data_ok); end
        if (inst_rdata !== 32'hA5A5_0001) begin failures++; $display("FAIL route_inst_rdata got=%0h exp=a5a50001", inst_rdata); end
        step();
        rvalid = 0; data_req = 1; data_addr = 32'h300;
        settle();
        step();
        data_req = 0; arready = 1;
        settle();
        step();
        arready = 0; data_req = 1; data_addr = 32'h304; rvalid = 1; rid = 4'd1;
        settle();
        if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1) begin failures++; $display("FAIL route_same_cycle got=%0h%0h exp=11", data_addr_ok, data_data_ok); end
        step();
        rvalid = 0; data_req = 0; arready = 1;
        settle();
        step();
        arready = 0; data_req = 1; data_addr = 32'h308;
        settle();
        if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL route_second got=%0h exp=1", data_addr_ok); end
        step();
        data_req = 0; arready = 1;
        settle();
        step();
        arready = 0; data_req = 1; data_addr = 32'h30C;
        settle();
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL route_full got=%0h exp=0", data_addr_ok); end
        rvalid = 1; rid = 4'd5;
        settle();
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++; $display("FAIL route_rid5 got=%0h%0h exp=00", inst_data_ok, data_data_ok); end
        step();
        rvalid = 0;
        settle();
        if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL route_rid5_cnt got=%0h exp=0", data_addr_ok); end
        rvalid = 1; rid = 4'd1;
        settle();
        step();
        rvalid = 0;
        settle();
        if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL route_after_resp got=%0h exp=1", data_addr_ok); end
        step();
        data_req = 0;
        step();
    endtask

    task automatic test_reset_in_send();
        do_reset();
        data_req = 1; data_addr = 32'h500;
        settle();
        step();
        data_req = 0;
        settle();
        checks += 3;
        if (arvalid !== 1'b1) begin failures++; $display("FAIL rst_send_pre got=%0h exp=1", arvalid); end
        reset = 1;
        settle();
        step();
        reset = 0; inst_req = 1; inst_addr = 32'h600;
        settle();
        if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_send_arvalid got=%0h exp=0", arvalid); end
        if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rst_send_accept got=%0h exp=1", inst_addr_ok); end
        step();
        inst_req = 0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        pool[0] = 32'h8000; pool[1] = 32'h8002; pool[2] = 32'h8004; pool[3] = 32'h8010;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            inst_req  = $urandom_range(0, 1) == 1;
            data_req  = $urandom_range(0, 2) == 0;
            inst_addr = pool[$urandom_range(0, 3)];
            data_addr = pool[$urandom_range(0, 3)];
            inst_size = 2'($urandom_range(0, 2));
            data_size = 2'($urandom_range(0, 2));
            wr_busy   = $urandom_range(0, 3) == 0;
            wr_addr   = pool[$urandom_range(0, 3)];
            arready   = $urandom_range(0, 1) == 1;
            rvalid    = $urandom_range(0, 2) == 0;
            case ($urandom_range(0, 2))
                0: rid = 4'd0;
                1: rid = 4'd1;
                default: rid = 4'd5;
            endcase
            rdata = $urandom;
            settle();
            checks += 6;
            if (inst_addr_ok !== e_iaok) begin failures++; $display("FAIL rnd_inst_addr_ok n%0d got=%0h exp=%0h", n, inst_addr_ok, e_iaok); end
            if (data_addr_ok !== e_daok) begin failures++; $display("FAIL rnd_data_addr_ok n%0d got=%0h exp=%0h", n, data_addr_ok, e_daok); end
            if (inst_data_ok !== e_idok) begin failures++; $display("FAIL rnd_inst_data_ok n%0d got=%0h exp=%0h", n, inst_data_ok, e_idok); end
            if (data_data_ok !== e_ddok) begin failures++; $display("FAIL rnd_data_data_ok n%0d got=%0h exp=%0h", n, data_data_ok, e_ddok); end
            if (arvalid !== m_busy) begin failures++; $display("FAIL rnd_arvalid n%0d got=%0h exp=%0h", n, arvalid, m_busy); end
            if (data_rdata !== rdata || inst_rdata !== rdata) begin failures++; $display("FAIL rnd_rdata n%0d got=%0h/%0h exp=%0h", n, inst_rdata, data_rdata, rdata); end
            if (m_busy) begin
                checks++;
                if (arid !== m_arid || araddr !== m_araddr || arsize !== m_arsize) begin
                    failures++;
                    $display("FAIL rnd_ar_fields n%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", n, arid, araddr, arsize, m_arid, m_araddr, m_arsize);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_priority();
        test_limit();
        test_write_hazard();
        test_routing();
        test_reset_in_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read-address/read-data channel pair between the CPU's instruction-fetch and data-load sram-like requesters. It sits between the pipeline's sram-like ports and the AXI master pins at the CPU top, beside the write path. It also enforces a per-port outstanding-read limit, routes responses back by `rid`, and holds off reads that hit the word address of a pending write.

## Interface
Parameters:
- `MAX_OUTST`, 2: max in-flight reads per port (1..3).
- `ID_INST`, 4'd0: `arid` used for instruction reads.
- `ID_DATA`, 4'd1: `arid` used for data reads.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1: instruction read request.
- `inst_size` in 2: 0/1/2 = byte/half/word.
- `inst_addr` in 32: instruction read address.
- `inst_addr_ok` out 1: instruction request accepted this cycle.
- `inst_data_ok` out 1: instruction read data valid this cycle.
- `inst_rdata` out 32: instruction read data.
- `data_req` in 1: data read request (read-only port).
- `data_size` in 2: 0/1/2 = byte/half/word.
- `data_addr` in 32: data read address.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data read data valid this cycle.
- `data_rdata` out 32: data read data.
- `wr_busy` in 1: the write path holds an unacknowledged write.
- `wr_addr` in 32: address of that pending write.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1, `arready` in 1: AXI read-address channel.
- `rid` in 4, `rdata` in 32, `rvalid` in 1, `rready` out 1: AXI read-data channel.

## Operation
- AR state machine has two states:
  - `AR_IDLE`: `arvalid` = 0. If any port is eligible, grant one, latch its `{id, addr, size}` into the AR register, pulse its `*_addr_ok` for that cycle (combinational), and go to `AR_SEND`.
  - `AR_SEND`: `arvalid` = 1 and the AR register is held stable. On `arready`, go to `AR_IDLE`. No `*_addr_ok` is issued in `AR_SEND`.
- A port is eligible when all hold:
  - `req` = 1.
  - Its outstanding count < `MAX_OUTST`.
  - It does not hit a pending write: NOT (`wr_busy` && `wr_addr[31:2]` == `addr[31:2]`). This check applies to both ports.
- Priority is fixed: data over instruction.
- Constant AR fields: `arlen` = 0, `arburst` = 2'b01, `arlock` = 0, `arcache` = 0, `arprot` = 0.
- `arsize` = {1'b0, size}.
- `araddr` is passed unaligned.
- `rready` is tied to 1; both sinks always accept data.
- Response routing is combinational:
  - `rvalid` && `rid` == `ID_INST` gives `inst_data_ok` = 1.
  - `rvalid` && `rid` == `ID_DATA` gives `data_data_ok` = 1.
  - `rdata` fans out to both `*_rdata` unmodified.
  - Any other `rid` is dropped: no `data_ok`, counters unchanged.
- Per-port outstanding counter (2 bits):
  - +1 on that port's `addr_ok`.
  - −1 on that port's `data_ok`.
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_OUTST`; never underflows. A `data_ok` seen at count 0 is still forwarded, and the counter holds.
- Ordering: same-ID AXI ordering keeps each port in order. Cross-port order is not guaranteed.

## Timing
- Reset values:
  - State `AR_IDLE`; `arvalid` = 0; `arid` = 0, `araddr` = 0, `arsize` = 0.
  - Both counters 0; both `addr_ok` = 0.
  - `rready` = 1.
- Request accepted in cycle N gives `arvalid` = 1 from N+1. One AR issue takes at least 2 cycles (one-cycle bubble in `AR_IDLE`).
- `data_ok` has zero-cycle latency from `rvalid`.
- `arready` during `AR_IDLE` is ignored.
- Requests may change or drop while not granted; nothing is latched without `addr_ok`.
- Reset asserted mid-`AR_SEND` abandons the transaction. Counters clear; system reset of the interconnect is required alongside.
- `wr_busy` rising while a hitting request waits: the request stays blocked until `wr_busy` falls, then is eligible the same cycle.

## Structure
- Package `axi_rd_arb_pkg`:
  - State enum `{AR_IDLE, AR_SEND}`.
  - Constants `AXI_BURST_INCR`, `ARLEN_SINGLE`.
  - Default IDs.
- Sub-module `rd_outst_counter`: saturating up/down counter with `full` flag and `MAX_OUTST` parameter. Instantiated once per port.

## Test plan
- **Single read:** `data_req` @0x1000, size 2 → `data_addr_ok` in cycle 0; `arvalid`, `arid` = 1, `araddr` = 0x1000, `arsize` = 2 in cycle 1. Hold `arready` low 3 cycles; AR fields stay stable. Then `rvalid`, `rid` = 1, `rdata` = 0xDEADBEEF → `data_data_ok`, `data_rdata` = 0xDEADBEEF.
- **Priority:** `inst_req` and `data_req` together → data granted first; inst granted in the first `AR_IDLE` after the data AR handshake.
- **Limit:** `MAX_OUTST` = 2 with no R responses → exactly 2 inst `addr_ok`, then `inst_req` stalls. One response → third request accepted.
- **Write hazard:** `wr_busy` = 1, `wr_addr` = 0x2004, `data_addr` = 0x2006 → no `addr_ok`. `data_addr` = 0x2008 → accepted. `wr_busy` falls → 0x2006 accepted that cycle.
- **Response routing:** `rid` = 0 → only `inst_data_ok`. `rid` = 5 → neither `data_ok`, counters unchanged. Same-cycle `addr_ok` and `data_ok` on one port → count unchanged.
- **Reset in `AR_SEND`:** assert `reset` for 1 cycle → next cycle `arvalid` = 0, counters 0, new request accepted.
